// File: rtl/ch4_reg_length.sv
// ch4_reg_length: noise-channel (channel 4) control registers NR41-NR44,
// pending-trigger latch, 6-bit length timer and CPU read-back for FF20-FF23.
// Ports carry i_/o_ prefixes so that the FF21/FF22 address selects and the
// FF21/FF22 register outputs have distinct names.
module ch4_reg_length (
    input  logic       i_dova_phi,
    input  logic       i_apu_reset,
    input  logic       i_cpu_wr,
    input  logic       i_cpu_rd,
    input  logic       i_ff20,
    input  logic       i_ff21,
    input  logic       i_ff22,
    input  logic       i_ff23,
    input  logic [7:0] i_d_in,
    output logic [7:0] o_d_out,
    output logic       o_d_oe,
    input  logic       i_len_tick,
    input  logic       i_rst_ff23_d7,
    output logic [7:0] o_ff21,
    output logic [7:0] o_nff21,
    output logic [7:0] o_ff22,
    output logic [7:0] o_nff22,
    output logic       o_ff23_d6,
    output logic       o_ff23_d7,
    output logic       o_fugo_q,
    output logic [5:0] o_len_cnt
);

    logic [7:0] r_ff21;
    logic [7:0] r_ff22;
    logic       r_ff23_d6;
    logic       r_ff23_d7;
    logic       r_fugo_q;
    logic [5:0] r_len_cnt;

    logic       w_wr20;
    logic       w_wr21;
    logic       w_wr22;
    logic       w_wr23;
    logic       w_trig;
    logic       w_count;

    assign w_wr20  = i_cpu_wr & i_ff20;
    assign w_wr21  = i_cpu_wr & i_ff21;
    assign w_wr22  = i_cpu_wr & i_ff22;
    assign w_wr23  = i_cpu_wr & i_ff23;
    assign w_trig  = w_wr23 & i_d_in[7];
    assign w_count = i_len_tick & r_ff23_d6 & ~r_fugo_q;

    // NR42 / NR43 data registers
    always_ff @(posedge i_dova_phi or posedge i_apu_reset) begin
        if (i_apu_reset) begin
            r_ff21 <= '0;
            r_ff22 <= '0;
        end else begin
            if (w_wr21) r_ff21 <= i_d_in;
            if (w_wr22) r_ff22 <= i_d_in;
        end
    end

    // NR44 length-enable bit and pending-trigger latch (write beats ack)
    always_ff @(posedge i_dova_phi or posedge i_apu_reset) begin
        if (i_apu_reset) begin
            r_ff23_d6 <= 1'b0;
            r_ff23_d7 <= 1'b0;
        end else begin
            if (w_wr23) r_ff23_d6 <= i_d_in[6];
            if (w_trig) r_ff23_d7 <= 1'b1;
            else if (i_rst_ff23_d7) r_ff23_d7 <= 1'b0;
        end
    end

    // Length counter: FF20 load > trigger reload after expiry > tick increment
    always_ff @(posedge i_dova_phi or posedge i_apu_reset) begin
        if (i_apu_reset) begin
            r_len_cnt <= '0;
            r_fugo_q  <= 1'b0;
        end else if (w_wr20) begin
            r_len_cnt <= i_d_in[5:0];
            r_fugo_q  <= 1'b0;
        end else if (w_trig && r_fugo_q) begin
            r_len_cnt <= '0;
            r_fugo_q  <= 1'b0;
        end else if (w_count) begin
            r_len_cnt <= r_len_cnt + 6'd1;
            if (r_len_cnt == 6'd63) r_fugo_q <= 1'b1;
        end
    end

    // CPU read-back mux; unselected and write-only bits read as 1
    always_comb begin
        o_d_out = '1;
        if (i_ff21)      o_d_out = r_ff21;
        else if (i_ff22) o_d_out = r_ff22;
        else if (i_ff23) o_d_out = {1'b1, r_ff23_d6, 6'b111111};
    end

    assign o_d_oe    = i_cpu_rd & (i_ff20 | i_ff21 | i_ff22 | i_ff23);
    assign o_ff21    = r_ff21;
    assign o_nff21   = ~r_ff21;
    assign o_ff22    = r_ff22;
    assign o_nff22   = ~r_ff22;
    assign o_ff23_d6 = r_ff23_d6;
    assign o_ff23_d7 = r_ff23_d7;
    assign o_fugo_q  = r_fugo_q;
    assign o_len_cnt = r_len_cnt;

endmodule

// File: tb/tb_ch4_reg_length.sv
// Testbench for ch4_reg_length: table of one-cycle vectors with hand-computed
// expected state, plus hand-written async reset sequences.
module tb_ch4_reg_length;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_wr, cpu_rd, len_tick, rst_d7;
    logic [3:0] sel;
    logic [7:0] d_in;
    logic [7:0] d_out, ff21, nff21, ff22, nff22;
    logic       d_oe, d6, d7, fugo;
    logic [5:0] len_cnt;

    always #5 clk = ~clk;

    ch4_reg_length dut (
        .i_dova_phi    (clk),
        .i_apu_reset   (rst),
        .i_cpu_wr      (cpu_wr),
        .i_cpu_rd      (cpu_rd),
        .i_ff20        (sel[0]),
        .i_ff21        (sel[1]),
        .i_ff22        (sel[2]),
        .i_ff23        (sel[3]),
        .i_d_in        (d_in),
        .o_d_out       (d_out),
        .o_d_oe        (d_oe),
        .i_len_tick    (len_tick),
        .i_rst_ff23_d7 (rst_d7),
        .o_ff21        (ff21),
        .o_nff21       (nff21),
        .o_ff22        (ff22),
        .o_nff22       (nff22),
        .o_ff23_d6     (d6),
        .o_ff23_d7     (d7),
        .o_fugo_q      (fugo),
        .o_len_cnt     (len_cnt)
    );

    typedef struct {
        string      name;
        bit         wr, rd, tick, rd7;
        bit [3:0]   sel;
        bit [7:0]   d;
        bit [7:0]   e21, e22;
        bit         e6, e7, ef;
        bit [5:0]   ec;
        bit [7:0]   edo;
        bit         eoe;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // running expected register state used while filling the table
    bit [7:0] s21, s22;
    bit       s6, s7, sf;
    bit [5:0] sc;

    function automatic logic [49:0] pack(bit [7:0] a21, bit [7:0] a22, bit a6,
                                         bit a7, bit af, bit [5:0] ac,
                                         bit [7:0] ado, bit aoe);
        return {a21, ~a21, a22, ~a22, a6, a7, af, ac, ado, aoe};
    endfunction

    function automatic logic [49:0] actual();
        return {ff21, nff21, ff22, nff22, d6, d7, fugo, len_cnt, d_out, d_oe};
    endfunction

    task automatic check(string name, logic [49:0] act, logic [49:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cnt=%h fugo=%b d7=%b)",
                     name, act, exp, len_cnt, fugo, d7);
        end
    endtask

    // add one vector; expectations are the bench's running state after the edge
    task automatic add(string name, bit wr, bit rd, bit [3:0] s, bit [7:0] d,
                       bit tick, bit rd7, bit [7:0] edo);
        vec_t v;
        v.name = name; v.wr = wr; v.rd = rd; v.sel = s; v.d = d;
        v.tick = tick; v.rd7 = rd7;
        v.e21 = s21; v.e22 = s22; v.e6 = s6; v.e7 = s7; v.ef = sf; v.ec = sc;
        v.edo = edo; v.eoe = rd && (s != 4'b0000);
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        cpu_wr = 0; cpu_rd = 0; sel = '0; d_in = '0; len_tick = 0; rst_d7 = 0;
    endtask

    initial begin
        idle_inputs();
        s21 = 0; s22 = 0; s6 = 0; s7 = 0; sf = 0; sc = 0;

        // reads straight after reset
        add("rd20_reset", 0, 1, 4'b0001, 8'h00, 0, 0, 8'hFF);
        add("rd23_reset", 0, 1, 4'b1000, 8'h00, 0, 0, 8'hBF);
        add("idle",       0, 0, 4'b0000, 8'h00, 0, 0, 8'hFF);
        // length expiry from 0x3C
        sc = 6'h3C;
        add("wr20_3C",    1, 0, 4'b0001, 8'h3C, 0, 0, 8'hFF);
        s6 = 1;
        add("wr23_40",    1, 0, 4'b1000, 8'h40, 0, 0, 8'hFF);
        sc = 6'h3D; add("tick1", 0, 0, 4'b0000, 8'h00, 1, 0, 8'hFF);
        sc = 6'h3E; add("tick2", 0, 0, 4'b0000, 8'h00, 1, 0, 8'hFF);
        sc = 6'h3F; add("tick3", 0, 0, 4'b0000, 8'h00, 1, 0, 8'hFF);
        sc = 6'h00; sf = 1;
        add("tick4_expire", 0, 0, 4'b0000, 8'h00, 1, 0, 8'hFF);
        add("tick5_held",   0, 0, 4'b0000, 8'h00, 1, 0, 8'hFF);
        // retrigger after expiry, then channel acknowledge
        sc = 0; sf = 0; s7 = 1;
        add("retrig_C0",  1, 0, 4'b1000, 8'hC0, 0, 0, 8'hFF);
        s7 = 0;
        add("ack_d7",     0, 0, 4'b0000, 8'h00, 0, 1, 8'hFF);
        for (int i = 0; i < 64; i++) begin
            sc = 6'(i + 1);
            sf = (i == 63);
            add("tick64", 0, 0, 4'b0000, 8'h00, 1, 0, 8'hFF);
        end
        // collisions
        sc = 6'h05; sf = 0;
        add("wr20_05",    1, 0, 4'b0001, 8'h05, 0, 0, 8'hFF);
        sc = 6'h10;
        add("wr20_tick",  1, 0, 4'b0001, 8'h10, 1, 0, 8'hFF);
        s7 = 1;
        add("trig_ack",   1, 0, 4'b1000, 8'hC0, 0, 1, 8'hFF);
        s7 = 0;
        add("ack_only",   0, 0, 4'b0000, 8'h00, 0, 1, 8'hFF);
        // length disabled
        sc = 6'h3F;
        add("wr20_3F",    1, 0, 4'b0001, 8'h3F, 0, 0, 8'hFF);
        s6 = 0;
        add("wr23_00",    1, 0, 4'b1000, 8'h00, 0, 0, 8'hBF);
        for (int i = 0; i < 3; i++)
            add("tick_dis", 0, 0, 4'b0000, 8'h00, 1, 0, 8'hFF);
        // register bus
        s21 = 8'hA5;
        add("wr21_A5",    1, 0, 4'b0010, 8'hA5, 0, 0, 8'hA5);
        s22 = 8'h3C;
        add("wr22_3C",    1, 0, 4'b0100, 8'h3C, 0, 0, 8'h3C);
        add("rd21",       0, 1, 4'b0010, 8'h00, 0, 0, 8'hA5);
        add("rd22",       0, 1, 4'b0100, 8'h00, 0, 0, 8'h3C);
        add("rd23_d6_0",  0, 1, 4'b1000, 8'h00, 0, 0, 8'hBF);
        // set up a mid-count state for the reset sequence
        sc = 6'h20;
        add("wr20_20",    1, 0, 4'b0001, 8'h20, 0, 0, 8'hFF);
        s6 = 1;
        add("wr23_40b",   1, 0, 4'b1000, 8'h40, 0, 0, 8'hFF);
        sc = 6'h21; add("tick_a", 0, 0, 4'b0000, 8'h00, 1, 0, 8'hFF);
        sc = 6'h22; add("tick_b", 0, 0, 4'b0000, 8'h00, 1, 0, 8'hFF);

        // initial async reset, checked without any clock edge
        rst = 1;
        #1;
        check("reset_state", actual(), pack(0, 0, 0, 0, 0, 0, 8'hFF, 0));
        #1 rst = 0;

        foreach (vq[k]) begin
            cpu_wr = vq[k].wr; cpu_rd = vq[k].rd; sel = vq[k].sel;
            d_in = vq[k].d; len_tick = vq[k].tick; rst_d7 = vq[k].rd7;
            @(posedge clk);
            #1;
            check(vq[k].name, actual(),
                  pack(vq[k].e21, vq[k].e22, vq[k].e6, vq[k].e7, vq[k].ef,
                       vq[k].ec, vq[k].edo, vq[k].eoe));
        end

        // mid-count reset takes effect immediately, between clock edges
        idle_inputs();
        #2 rst = 1;
        #1;
        check("midcount_reset", actual(), pack(0, 0, 0, 0, 0, 0, 8'hFF, 0));
        cpu_rd = 1; sel = 4'b1000;
        #1;
        check("reset_rd23", actual(), pack(0, 0, 0, 0, 0, 0, 8'hBF, 1));
        idle_inputs();
        rst = 0;
        // with enable cleared by reset, ticks must not count
        len_tick = 1;
        @(posedge clk);
        #1;
        len_tick = 0;
        check("post_reset_tick", actual(), pack(0, 0, 0, 0, 0, 0, 8'hFF, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
